// File: rtl/gemm_seq_pkg.sv
// gemm_seq_pkg
// Shared encodings for the GEMM instruction path: opcodes, buffer ids,
// systolic-array control-state encodings and the sequencer's internal FSM
// states. Imported by the sequencer, the array top and the instruction reader.
package gemm_seq_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_LD       = 4'd2;
  localparam logic [3:0] OP_ST       = 4'd3;
  localparam logic [3:0] OP_GEMM     = 4'd4;
  localparam logic [3:0] OP_DRAINSYS = 4'd5;

  // Buffer ids (3 is reserved and rejected)
  localparam logic [1:0] BUF_TOP  = 2'd0;
  localparam logic [1:0] BUF_LEFT = 2'd1;
  localparam logic [1:0] BUF_DOWN = 2'd2;
  localparam logic [1:0] BUF_RSVD = 2'd3;

  // Array control-state encodings seen by the systolic array
  localparam logic [3:0] CTRL_IDLE   = 4'd0;
  localparam logic [3:0] CTRL_WARMUP = 4'd1;
  localparam logic [3:0] CTRL_STEADY = 4'd2;
  localparam logic [3:0] CTRL_DRAIN  = 4'd3;

  // Internal sequencer states; S_STORE has no array-visible encoding
  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_STEADY,
    S_DRAIN,
    S_STORE
  } state_e;

endpackage

// File: rtl/gemm_sequencer.sv
// gemm_sequencer
// Accepts decoded instructions over valid/ready, keeps per-buffer base
// addresses, sequences the array control state (IDLE/WARMUP/STEADY/DRAIN)
// and drives the SRAM read windows plus the output-buffer readback for ST.
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_inst_valid / o_inst_ready   instruction handshake (ready only when idle)
//   i_opcode, i_buf_id, i_mem_loc decoded instruction fields
//   o_ctrl_state                  array control state
//   o_{top,left,down}_sram_rd_{start,end}_addr  registered read windows
//   o_down_rd_en, o_down_rd_addr  store readback
//   o_done, o_err                 one-cycle completion / illegal pulses
module gemm_sequencer
  import gemm_seq_pkg::*;
#(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int OPCODE_WIDTH         = 4,
  parameter int BUF_ID_WIDTH         = 2,
  parameter int MEM_LOC_WIDTH        = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_inst_valid,
  output logic                            o_inst_ready,
  input  logic [OPCODE_WIDTH-1:0]         i_opcode,
  input  logic [BUF_ID_WIDTH-1:0]         i_buf_id,
  input  logic [MEM_LOC_WIDTH-1:0]        i_mem_loc,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_addr,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int A = LOG2_SRAM_BANK_DEPTH;

  localparam logic [OPCODE_WIDTH-1:0] LD   = OPCODE_WIDTH'(OP_LD);
  localparam logic [OPCODE_WIDTH-1:0] ST   = OPCODE_WIDTH'(OP_ST);
  localparam logic [OPCODE_WIDTH-1:0] GEMM = OPCODE_WIDTH'(OP_GEMM);
  localparam logic [OPCODE_WIDTH-1:0] DRN  = OPCODE_WIDTH'(OP_DRAINSYS);

  localparam logic [BUF_ID_WIDTH-1:0] B_TOP  = BUF_ID_WIDTH'(BUF_TOP);
  localparam logic [BUF_ID_WIDTH-1:0] B_LEFT = BUF_ID_WIDTH'(BUF_LEFT);
  localparam logic [BUF_ID_WIDTH-1:0] B_DOWN = BUF_ID_WIDTH'(BUF_DOWN);

  localparam logic [A-1:0] ROW_M1     = A'(NUM_ROW - 1);
  localparam logic [A:0]   DRAIN_LAST = (A+1)'(NUM_ROW + NUM_COL - 2);
  localparam logic [A:0]   STORE_LAST = (A+1)'(NUM_ROW - 1);

  state_e       state_q, state_d;
  logic [A:0]   cnt_q, cnt_d;
  logic [A-1:0] len_q, len_d;   // K-1 of the running GEMM
  logic [A-1:0] top_base_q, top_base_d, left_base_q, left_base_d;
  logic [A-1:0] down_base_q, down_base_d;
  logic [A-1:0] top_s_q, top_s_d, top_e_q, top_e_d;
  logic [A-1:0] left_s_q, left_s_d, left_e_q, left_e_d;
  logic [A-1:0] down_s_q, down_s_d, down_e_q, down_e_d;
  logic [A-1:0] rd_addr_q, rd_addr_d;
  logic         rd_en_q, rd_en_d, done_q, done_d, err_q, err_d;
  logic [A-1:0] loc;

  // Only the low A bits of the operand are meaningful here
  logic unused_mem_hi;
  assign unused_mem_hi = ^i_mem_loc[MEM_LOC_WIDTH-1:A];
  assign loc = i_mem_loc[A-1:0];

  assign o_inst_ready = (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    top_base_d  = top_base_q;
    left_base_d = left_base_q;
    down_base_d = down_base_q;
    top_s_d     = top_s_q;
    top_e_d     = top_e_q;
    left_s_d    = left_s_q;
    left_e_d    = left_e_q;
    down_s_d    = down_s_q;
    down_e_d    = down_e_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: if (i_inst_valid) begin
        case (i_opcode)
          LD: begin
            case (i_buf_id)
              B_TOP:   top_base_d  = loc;
              B_LEFT:  left_base_d = loc;
              B_DOWN:  down_base_d = loc;
              default: err_d       = 1'b1;
            endcase
          end
          GEMM: begin
            len_d    = loc;
            top_s_d  = top_base_q;
            top_e_d  = top_base_q + loc;    // wraps mod 2^A
            left_s_d = left_base_q;
            left_e_d = left_base_q + loc;
            cnt_d    = '0;
            state_d  = S_WARMUP;
          end
          DRN: begin
            down_s_d = down_base_q;
            down_e_d = down_base_q + ROW_M1;
            cnt_d    = '0;
            state_d  = S_DRAIN;
          end
          ST: begin
            // First readback goes out in the accept cycle itself
            rd_en_d   = 1'b1;
            rd_addr_d = down_base_q;
            cnt_d     = '0;
            state_d   = S_STORE;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_WARMUP: state_d = S_STEADY;
      S_STEADY: begin
        if (cnt_q == {1'b0, len_q}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        if (cnt_q == STORE_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      top_base_q  <= '0;
      left_base_q <= '0;
      down_base_q <= '0;
      top_s_q     <= '0;
      top_e_q     <= '0;
      left_s_q    <= '0;
      left_e_q    <= '0;
      down_s_q    <= '0;
      down_e_q    <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      top_base_q  <= top_base_d;
      left_base_q <= left_base_d;
      down_base_q <= down_base_d;
      top_s_q     <= top_s_d;
      top_e_q     <= top_e_d;
      left_s_q    <= left_s_d;
      left_e_q    <= left_e_d;
      down_s_q    <= down_s_d;
      down_e_q    <= down_e_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // S_STORE is invisible to the array, which stays IDLE during readback
  always_comb begin
    o_ctrl_state = CTRL_WIDTH'(CTRL_IDLE);
    case (state_q)
      S_WARMUP: o_ctrl_state = CTRL_WIDTH'(CTRL_WARMUP);
      S_STEADY: o_ctrl_state = CTRL_WIDTH'(CTRL_STEADY);
      S_DRAIN:  o_ctrl_state = CTRL_WIDTH'(CTRL_DRAIN);
      default:  o_ctrl_state = CTRL_WIDTH'(CTRL_IDLE);
    endcase
  end

  assign o_top_sram_rd_start_addr  = top_s_q;
  assign o_top_sram_rd_end_addr    = top_e_q;
  assign o_left_sram_rd_start_addr = left_s_q;
  assign o_left_sram_rd_end_addr   = left_e_q;
  assign o_down_sram_rd_start_addr = down_s_q;
  assign o_down_sram_rd_end_addr   = down_e_q;
  assign o_down_rd_en              = rd_en_q;
  assign o_down_rd_addr            = rd_addr_q;
  assign o_done                    = done_q;
  assign o_err                     = err_q;

endmodule

// File: tb/tb_gemm_sequencer.sv
// tb_gemm_sequencer
// Directed stimulus with hand-computed expectations pushed into a queue;
// a negedge monitor pops one record per DUT output event (done, err,
// readback) and checks it, along with per-state cycle counts since the
// previous completion.
module tb_gemm_sequencer;
  import gemm_seq_pkg::*;

  logic       clk = 1'b0, rst = 1'b1;
  logic       i_inst_valid = 1'b0;
  logic       o_inst_ready;
  logic [3:0] i_opcode = '0;
  logic [1:0] i_buf_id = '0;
  logic [9:0] i_mem_loc = '0;
  logic [3:0] o_ctrl_state;
  logic [4:0] ts, te, ls, le, ds, de, rd_addr;
  logic       rd_en, done, err;

  gemm_sequencer dut (
    .clk(clk), .rst(rst),
    .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_opcode(i_opcode), .i_buf_id(i_buf_id), .i_mem_loc(i_mem_loc),
    .o_ctrl_state(o_ctrl_state),
    .o_top_sram_rd_start_addr(ts), .o_top_sram_rd_end_addr(te),
    .o_left_sram_rd_start_addr(ls), .o_left_sram_rd_end_addr(le),
    .o_down_sram_rd_start_addr(ds), .o_down_sram_rd_end_addr(de),
    .o_down_rd_en(rd_en), .o_down_rd_addr(rd_addr),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  localparam int K_DONE = 0, K_ERR = 1, K_RD = 2;

  typedef struct {
    int kind;
    int ts, te, ls, le, ds, de, ra;
    int warm, steady, drain, busy;
  } exp_t;

  exp_t q[$];
  int n_assert = 0, n_fail = 0;
  int cw = 0, cs = 0, cd = 0, cb = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_assert++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int t_s, input int t_e,
                         input int l_s, input int l_e, input int d_s,
                         input int d_e, input int ra, input int w,
                         input int s, input int d, input int b);
    exp_t e;
    e.kind = kind; e.ts = t_s; e.te = t_e; e.ls = l_s; e.le = l_e;
    e.ds = d_s; e.de = d_e; e.ra = ra;
    e.warm = w; e.steady = s; e.drain = d; e.busy = b;
    q.push_back(e);
  endtask

  // Drive at negedge, hold valid until ready, release just after accept edge
  task automatic send(input logic [3:0] op, input logic [1:0] b,
                      input logic [9:0] loc);
    int guard;
    @(negedge clk);
    i_inst_valid = 1'b1; i_opcode = op; i_buf_id = b; i_mem_loc = loc;
    guard = 0;
    while (!o_inst_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", guard, 0);
    @(posedge clk);
    #1 i_inst_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"}, int'(o_ctrl_state), 0);
    chk({tag, "_ready"}, int'(o_inst_ready), 1);
    chk({tag, "_addrs"}, int'({ts, te, ls, le, ds, de, rd_addr}), 0);
    chk({tag, "_pulses"}, int'({rd_en, done, err}), 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int act_kind;
    if (rst) begin
      cw = 0; cs = 0; cd = 0; cb = 0;
    end else begin
      if (o_ctrl_state == 4'd1) cw++;
      if (o_ctrl_state == 4'd2) cs++;
      if (o_ctrl_state == 4'd3) cd++;
      if (!o_inst_ready) cb++;
      if (done || err || rd_en) begin
        chk("done_err_exclusive", int'(done & err), 0);
        chk("event_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          act_kind = done ? K_DONE : (err ? K_ERR : K_RD);
          chk("event_kind", act_kind, e.kind);
          if (e.kind == K_RD) begin
            chk("rd_addr", int'(rd_addr), e.ra);
            chk("rd_ctrl_idle", int'(o_ctrl_state), 0);
          end else begin
            chk("top_window", int'({ts, te}), (e.ts << 5) | e.te);
            chk("left_window", int'({ls, le}), (e.ls << 5) | e.le);
            chk("down_window", int'({ds, de}), (e.ds << 5) | e.de);
            chk("evt_ctrl_idle", int'(o_ctrl_state), 0);
            chk("evt_ready", int'(o_inst_ready), 1);
            if (e.kind == K_DONE) begin
              chk("warmup_cycles", cw, e.warm);
              chk("steady_cycles", cs, e.steady);
              chk("drain_cycles", cd, e.drain);
              chk("busy_cycles", cb, e.busy);
              cw = 0; cs = 0; cd = 0; cb = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Basic GEMM, K=4
    send(OP_LD, BUF_TOP, 10'd3);
    send(OP_LD, BUF_LEFT, 10'd7);
    push_ev(K_DONE, 3, 6, 7, 10, 0, 0, 0, 1, 4, 0, 5);
    send(OP_GEMM, 2'd0, 10'd3);

    // Top window wraps 30..1; upper operand bits ignored
    send(OP_LD, BUF_TOP, 10'd30);
    push_ev(K_DONE, 30, 1, 7, 10, 0, 0, 0, 1, 4, 0, 5);
    send(OP_GEMM, 2'd0, 10'h3E3);

    // Drain then store readback
    send(OP_LD, BUF_DOWN, 10'd8);
    push_ev(K_DONE, 30, 1, 7, 10, 8, 11, 0, 0, 0, 7, 7);
    send(OP_DRAINSYS, 2'd0, 10'd0);
    for (int n = 0; n < 4; n++)
      push_ev(K_RD, 0, 0, 0, 0, 0, 0, 8 + n, 0, 0, 0, 0);
    push_ev(K_DONE, 30, 1, 7, 10, 8, 11, 0, 0, 0, 0, 4);
    send(OP_ST, 2'd0, 10'd0);

    // Illegal LD buffer and illegal opcode; bases must survive
    push_ev(K_ERR, 30, 1, 7, 10, 8, 11, 0, 0, 0, 0, 0);
    send(OP_LD, BUF_RSVD, 10'd5);
    push_ev(K_ERR, 30, 1, 7, 10, 8, 11, 0, 0, 0, 0, 0);
    send(4'd7, 2'd0, 10'd9);
    push_ev(K_DONE, 30, 30, 7, 7, 8, 11, 0, 1, 1, 0, 2);
    send(OP_GEMM, 2'd0, 10'd0);

    // Reset during the second STEADY cycle: no done, immediate clear
    send(OP_GEMM, 2'd0, 10'd3);
    @(posedge clk);
    @(posedge clk);
    #2 chk("steady_before_rst", int'(o_ctrl_state), 2);
    rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    #2 rst = 1'b0;
    push_ev(K_DONE, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    send(OP_GEMM, 2'd0, 10'd0);

    // Valid held while busy: second GEMM accepted once, right after done
    push_ev(K_DONE, 0, 1, 0, 1, 0, 0, 0, 1, 2, 0, 3);
    send(OP_GEMM, 2'd0, 10'd1);
    push_ev(K_DONE, 0, 2, 0, 2, 0, 0, 0, 1, 3, 0, 4);
    send(OP_GEMM, 2'd0, 10'd2);

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
